// File: rtl/watch_pkg.sv
// Shared types and constants for the watch set-mode time editor.
// Editor states, default field geometry, button indices and blink phases.
package watch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } edit_state_e;

  localparam int DEF_FIELD_W    = 8;
  localparam int DEF_NUM_FIELDS = 6;

  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;
  localparam int BTN_INC  = 2;
  localparam int BTN_DEC  = 3;

  localparam logic BLINK_SHOW = 1'b0;
  localparam logic BLINK_HIDE = 1'b1;

endpackage

// File: rtl/watch_btn_repeat.sv
// Press detector with hold-to-repeat for one button: one step on the press edge,
// one after HOLD_CYC held cycles, then one every RPT_CYC cycles while still held alone.
module watch_btn_repeat #(
  parameter int HOLD_CYC = 25_000_000,
  parameter int RPT_CYC  = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic solo,
  input  logic en,
  output logic step
);

  localparam int CNT_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] RPT_V  = CNT_W'(RPT_CYC);

  logic             prev_r;
  logic             rpt_r;
  logic [CNT_W-1:0] cnt_r;
  logic             qual_s;
  logic             at_lim_s;
  logic             step_s;

  // Qualify the press and detect the end of the current hold/repeat interval.
  always_comb begin
    qual_s   = level & solo & en;
    at_lim_s = (cnt_r == (rpt_r ? RPT_V : HOLD_V));
    step_s   = qual_s & ((level & ~prev_r) | at_lim_s);
  end

  // Previous level and hold counter; restarting the count at one keeps the repeat cadence exact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r <= 1'b0;
      rpt_r  <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      prev_r <= level;
      if (!qual_s) begin
        cnt_r <= {CNT_W{1'b0}};
        rpt_r <= 1'b0;
      end else if (at_lim_s) begin
        cnt_r <= CNT_W'(1);
        rpt_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign step = step_s;

endmodule

// File: rtl/watch_time_editor.sv
// Set-mode field editor: loads the live time, edits each field within its bounds,
// and hands the result to the timekeeper over a valid/ready commit.
module watch_time_editor import watch_pkg::*; #(
  parameter int NUM_FIELDS = DEF_NUM_FIELDS,
  parameter int FIELD_W    = DEF_FIELD_W,
  parameter int HOLD_CYC   = 25_000_000,
  parameter int RPT_CYC    = 5_000_000,
  localparam int VEC_W     = NUM_FIELDS * FIELD_W,
  localparam int CUR_W     = $clog2(NUM_FIELDS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_1s,
  input  logic                edit_req,
  input  logic                btn_next,
  input  logic                btn_prev,
  input  logic                btn_inc,
  input  logic                btn_dec,
  input  logic [VEC_W-1:0]    cur_time,
  input  logic [VEC_W-1:0]    lo_flat,
  input  logic [VEC_W-1:0]    hi_flat,
  input  logic                set_ready,
  output logic [VEC_W-1:0]    edit_val,
  output logic [CUR_W-1:0]    cursor,
  output logic [NUM_FIELDS:0] blank_mask,
  output logic                editing,
  output logic [VEC_W-1:0]    set_time,
  output logic                set_valid
);

  typedef logic [FIELD_W-1:0] field_t;
  localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(NUM_FIELDS);

  // An empty range (lo > hi) pins the field to lo.
  function automatic field_t clamp_field(input field_t v, input field_t lo, input field_t hi);
    field_t r;
    if (lo > hi)     r = lo;
    else if (v < lo) r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    return r;
  endfunction

  function automatic field_t step_field(input field_t v, input field_t lo, input field_t hi,
                                        input logic up);
    logic [FIELD_W:0] w;
    field_t           r;
    w = up ? ({1'b0, v} + {{FIELD_W{1'b0}}, 1'b1}) : ({1'b0, v} - {{FIELD_W{1'b0}}, 1'b1});
    if (lo > hi)     r = lo;
    else if (up)     r = (v >= hi) ? lo : w[FIELD_W-1:0];
    else             r = (v <= lo) ? hi : w[FIELD_W-1:0];
    return r;
  endfunction

  edit_state_e         state_r, state_s;
  logic [VEC_W-1:0]    edit_r, edit_s;
  logic [VEC_W-1:0]    set_time_r, set_time_s;
  logic [CUR_W-1:0]    cursor_r, cursor_s;
  logic [NUM_FIELDS:0] mask_r, mask_s;
  logic                blink_r, blink_s;
  logic                set_valid_r, set_valid_s;
  logic                editing_r, editing_s;
  logic                nprev_r, pprev_r;
  logic [3:0]          btn_s;
  logic                solo_s, in_edit_s;
  logic                next_ev_s, prev_ev_s, inc_step_s, dec_step_s, any_ev_s;

  // Decode the buttons: only a lone button produces an event.
  always_comb begin
    btn_s           = 4'b0000;
    btn_s[BTN_NEXT] = btn_next;
    btn_s[BTN_PREV] = btn_prev;
    btn_s[BTN_INC]  = btn_inc;
    btn_s[BTN_DEC]  = btn_dec;
    solo_s          = $onehot(btn_s);
    in_edit_s       = (state_r == EDIT);
    next_ev_s       = btn_next & ~nprev_r & solo_s;
    prev_ev_s       = btn_prev & ~pprev_r & solo_s;
    any_ev_s        = next_ev_s | prev_ev_s | inc_step_s | dec_step_s;
  end

  watch_btn_repeat #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC)) u_inc_rpt (
    .clk(clk), .rst(rst), .level(btn_inc), .solo(solo_s), .en(in_edit_s), .step(inc_step_s)
  );

  watch_btn_repeat #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC)) u_dec_rpt (
    .clk(clk), .rst(rst), .level(btn_dec), .solo(solo_s), .en(in_edit_s), .step(dec_step_s)
  );

  // Next-state and next-output logic for the editor.
  always_comb begin
    state_s     = state_r;
    edit_s      = edit_r;
    cursor_s    = cursor_r;
    blink_s     = blink_r ^ tick_1s;
    set_time_s  = set_time_r;
    set_valid_s = set_valid_r;
    case (state_r)
      IDLE: begin
        if (edit_req) begin
          for (int f = 0; f < NUM_FIELDS; f++) begin
            edit_s[f*FIELD_W +: FIELD_W] = clamp_field(cur_time[f*FIELD_W +: FIELD_W],
                                                       lo_flat[f*FIELD_W +: FIELD_W],
                                                       hi_flat[f*FIELD_W +: FIELD_W]);
          end
          cursor_s = {CUR_W{1'b0}};
          blink_s  = BLINK_SHOW;
          state_s  = EDIT;
        end else begin
          state_s = IDLE;
        end
      end
      EDIT: begin
        // Every field tracks its bounds each cycle; the cursor field also steps.
        for (int f = 0; f < NUM_FIELDS; f++) begin
          if ((cursor_r == CUR_W'(f)) && (inc_step_s || dec_step_s)) begin
            edit_s[f*FIELD_W +: FIELD_W] = step_field(
              clamp_field(edit_r[f*FIELD_W +: FIELD_W], lo_flat[f*FIELD_W +: FIELD_W],
                          hi_flat[f*FIELD_W +: FIELD_W]),
              lo_flat[f*FIELD_W +: FIELD_W], hi_flat[f*FIELD_W +: FIELD_W], inc_step_s);
          end else begin
            edit_s[f*FIELD_W +: FIELD_W] = clamp_field(edit_r[f*FIELD_W +: FIELD_W],
                                                       lo_flat[f*FIELD_W +: FIELD_W],
                                                       hi_flat[f*FIELD_W +: FIELD_W]);
          end
        end
        if (next_ev_s && (cursor_r != CUR_LAST)) begin
          cursor_s = cursor_r + CUR_W'(1);
        end else if (prev_ev_s && (cursor_r != {CUR_W{1'b0}})) begin
          cursor_s = cursor_r - CUR_W'(1);
        end else begin
          cursor_s = cursor_r;
        end
        if ((cursor_r == CUR_LAST) && inc_step_s) begin
          set_time_s  = edit_r;
          set_valid_s = 1'b1;
          state_s     = COMMIT;
        end else if ((cursor_r == CUR_LAST) && dec_step_s) begin
          state_s = IDLE;
        end else begin
          state_s = EDIT;
        end
        if (any_ev_s) begin
          blink_s = BLINK_SHOW;
        end else begin
          blink_s = blink_r ^ tick_1s;
        end
      end
      COMMIT: begin
        if (set_ready) begin
          set_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = COMMIT;
        end
      end
      default: begin
        state_s     = IDLE;
        set_valid_s = 1'b0;
      end
    endcase
    editing_s = (state_s != IDLE);
    if ((state_s == EDIT) && (blink_s == BLINK_HIDE)) begin
      mask_s = {{NUM_FIELDS{1'b0}}, 1'b1} << cursor_s;
    end else begin
      mask_s = {(NUM_FIELDS + 1){1'b0}};
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      edit_r      <= {VEC_W{1'b0}};
      cursor_r    <= {CUR_W{1'b0}};
      blink_r     <= BLINK_SHOW;
      set_time_r  <= {VEC_W{1'b0}};
      set_valid_r <= 1'b0;
      editing_r   <= 1'b0;
      mask_r      <= {(NUM_FIELDS + 1){1'b0}};
      nprev_r     <= 1'b0;
      pprev_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      edit_r      <= edit_s;
      cursor_r    <= cursor_s;
      blink_r     <= blink_s;
      set_time_r  <= set_time_s;
      set_valid_r <= set_valid_s;
      editing_r   <= editing_s;
      mask_r      <= mask_s;
      nprev_r     <= btn_next;
      pprev_r     <= btn_prev;
    end
  end

  assign edit_val   = edit_r;
  assign cursor     = cursor_r;
  assign blank_mask = mask_r;
  assign editing    = editing_r;
  assign set_time   = set_time_r;
  assign set_valid  = set_valid_r;

endmodule

// File: doc/watch_time_editor.md
# watch_time_editor

Parametrised time/date field editor for the watch set mode: loads the running time into NUM_FIELDS edit registers, steps a cursor across them, increments and decrements each field with per-field range wrap and press-and-hold auto-repeat, and commits the edited value to the timekeeper through a valid/ready handshake. It sits between the debounced push-buttons and the timekeeping counter. It also drives a per-field blank mask that the LCD text formatter uses for cursor blinking.

## Interface
Parameters:
- NUM_FIELDS, 6, number of editable fields; field 0 occupies the LSBs.
- FIELD_W, 8, width of each field (binary, not BCD).
- HOLD_CYC, 25_000_000, clk cycles a held inc/dec must stay asserted before auto-repeat starts.
- RPT_CYC, 5_000_000, clk cycles between auto-repeat steps.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- tick_1s  in  1  one-clk pulse per second; toggles the blink phase.
- edit_req  in  1  pulse; enter editing from IDLE.
- btn_next, btn_prev, btn_inc, btn_dec  in  1 each  debounced button levels.
- cur_time  in  NUM_FIELDS*FIELD_W  live time, loaded on edit entry.
- lo_flat, hi_flat  in  NUM_FIELDS*FIELD_W  inclusive per-field bounds; may change while editing.
- set_ready  in  1  timekeeper accepts set_time.
- edit_val  out  NUM_FIELDS*FIELD_W  current edit registers.
- cursor  out  $clog2(NUM_FIELDS+1)  0..NUM_FIELDS-1 = field; NUM_FIELDS = commit position.
- blank_mask  out  NUM_FIELDS+1  bit i high: blank position i this blink phase.
- editing  out  1  high in EDIT and COMMIT.
- set_time  out  NUM_FIELDS*FIELD_W  committed value.
- set_valid  out  1  commit request.

## Operation
- States: IDLE, EDIT, COMMIT.
- IDLE: edit_req -> load every field from cur_time, clamped into [lo,hi]; cursor=0, blink=0; go to EDIT.
- EDIT: next/prev move the cursor within 0..NUM_FIELDS and saturate at both ends.
- EDIT, cursor on a field: inc at hi wraps to lo; dec at lo wraps to hi. Arithmetic is done in FIELD_W+1 bits, so no overflow aliasing.
- EDIT, cursor = NUM_FIELDS: inc latches set_time from edit_val, raises set_valid, and moves to COMMIT. dec cancels to IDLE with no commit.
- COMMIT: hold set_valid high and set_time stable until set_ready is sampled high. Clear set_valid on that same edge and go to IDLE.
- Press events:
  - A button event is the rising edge of its level.
  - An event is accepted only if exactly one of the four buttons is high on that cycle. Otherwise it is ignored and the repeat counter is cleared.
- Auto-repeat: applies to inc/dec only, not in COMMIT.
  - After HOLD_CYC cycles held, emit one step, then one every RPT_CYC cycles while held.
  - Release or any second button stops the repeat.
- Bounds change while editing: any field outside [lo,hi] is clamped to the nearer bound on the next edge. Example: day 31 becomes 30 after month changes to April.
- lo > hi for a field: that field is forced to lo, and inc/dec are no-ops.
- Blink:
  - tick_1s toggles the blink phase; any accepted event clears it to 0 (visible).
  - blank_mask = one-hot(cursor) when EDIT and blink=1; otherwise 0.
- edit_req is ignored in EDIT and COMMIT.

## Timing
- Reset values: state IDLE, edit_val 0, cursor 0, blank_mask 0, editing 0, set_time 0, set_valid 0, blink 0, repeat counter 0.
- Button edge detection uses a registered previous level. A level first sampled high at edge n produces an updated edit_val/cursor at edge n (visible from cycle n+1).
- edit_req at edge n: edit_val is loaded and editing=1 from n+1.
- Commit: set_valid is high from the edge after the commit inc. The minimum handshake is 1 cycle when set_ready is already high.
- Clamp on bound change: 1 cycle.
- Reset asserted mid-edit or mid-commit: everything returns to reset values immediately, and any pending commit is dropped.

## Structure
- Shared package watch_pkg holds:
  - the state enum (IDLE/EDIT/COMMIT);
  - the default FIELD_W and NUM_FIELDS;
  - button index constants BTN_NEXT/PREV/INC/DEC;
  - blink phase constants.
- One sub-module, watch_btn_repeat: edge detect plus the HOLD_CYC/RPT_CYC counter. It is instantiated twice (inc and dec) and outputs a one-clk step pulse.

## Test plan
Bench overrides: HOLD_CYC=8, RPT_CYC=2; defaults otherwise.
- Reset mid-commit: assert rst while set_valid=1 -> all outputs 0 asynchronously; no set_valid after release.
- Enter edit with cur_time sec=59, min=59 (bounds 0..59) -> edit_val equals cur_time. Cursor 0, inc -> sec 0. dec -> sec 59.
- Move cursor to field 2 (hi=23), hold inc 20 cycles from value 22 -> steps at cycles 0, 8, 10, 12, 14, 16, 18 -> final value 22+7 wraps to 5.
- Press inc and next on the same cycle -> no change to cursor or fields. Press prev at cursor 0 -> cursor stays 0.
- Day field = 31, then lower hi to 30 -> day reads 30 one cycle later. Set lo=5, hi=3 -> field forced to 5.
- Cursor = NUM_FIELDS, inc with set_ready low for 4 cycles -> set_valid high 4+ cycles with stable set_time. Raise set_ready -> set_valid drops and state is IDLE. Repeat with dec -> no set_valid, editing=0.
